// File: rtl/uart_tx_fifo.sv
// Galaksija serial console transmitter: byte FIFO feeding an 8N1 serialiser.
// Bit timing follows the uart_rx cfg_divider convention (clocks per bit).
module uart_tx_fifo #(
    parameter int fifo_depth_log2 = 4,
    parameter int divider_width   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [divider_width-1:0] cfg_divider,
    input  logic [7:0]               data,
    input  logic                     valid,
    output logic                     ready,
    output logic                     ser_tx,
    output logic                     busy,
    output logic [fifo_depth_log2:0] fifo_level
);

    localparam int AW    = fifo_depth_log2;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW:0]              ptr_t;
    typedef logic [divider_width-1:0] div_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t LVL_FULL = ptr_t'(DEPTH);
    localparam div_t DIV_ONE  = div_t'(1);
    localparam div_t DIV_TWO  = div_t'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [7:0] r_mem [DEPTH];
    ptr_t       r_wptr;
    ptr_t       r_rptr;
    ptr_t       r_level;
    logic       r_ready;
    logic       r_busy;
    logic       r_tx;
    logic [7:0] r_shift;
    logic [2:0] r_bit;
    div_t       r_cnt;
    div_t       r_period;

    state_t     w_state_nxt;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_bit_end;
    div_t       w_div_eff;
    ptr_t       w_wptr_nxt;
    ptr_t       w_rptr_nxt;
    ptr_t       w_level_nxt;
    logic       w_tx_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_bit_nxt;
    div_t       w_cnt_nxt;
    div_t       w_period_nxt;

    assign w_push    = valid & r_ready;
    assign w_empty   = (r_level == '0);
    assign w_bit_end = (r_cnt == '0);
    // Dividers below 2 would give a zero-length or degenerate bit period.
    assign w_div_eff = (cfg_divider < DIV_TWO) ? DIV_TWO : cfg_divider;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_tx_nxt     = r_tx;
        w_shift_nxt  = r_shift;
        w_bit_nxt    = r_bit;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;

        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = r_period - DIV_ONE;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_cnt - DIV_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = r_period - DIV_ONE;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DIV_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - DIV_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Frame start: from IDLE or straight out of STOP with no gap.
        if (w_pop) begin
            w_state_nxt  = S_START;
            w_tx_nxt     = 1'b0;
            w_shift_nxt  = r_mem[r_rptr[AW-1:0]];
            w_period_nxt = w_div_eff;
            w_cnt_nxt    = w_div_eff - DIV_ONE;
            w_bit_nxt    = 3'd0;
        end
    end

    assign w_wptr_nxt  = w_push ? (r_wptr + PTR_ONE) : r_wptr;
    assign w_rptr_nxt  = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
    assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_tx     <= 1'b1;
            r_shift  <= '0;
            r_bit    <= '0;
            r_cnt    <= '0;
            r_period <= DIV_TWO;
        end else begin
            r_state  <= w_state_nxt;
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_level  <= w_level_nxt;
            r_ready  <= (w_level_nxt != LVL_FULL);
            r_busy   <= (w_state_nxt != S_IDLE) | (w_level_nxt != '0);
            r_tx     <= w_tx_nxt;
            r_shift  <= w_shift_nxt;
            r_bit    <= w_bit_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
        end
    end

    assign ready      = r_ready;
    assign ser_tx     = r_tx;
    assign busy       = r_busy;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: line waveform, FIFO behaviour, reset
// and divider handling checked against hand-built expected streams.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_divider;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        ser_tx;
    logic        busy;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    logic       cap   [$];
    logic       capb  [$];
    logic       exp_q [$];
    logic [7:0] rxq   [$];
    int         cap_wait;
    bit         cap_to;

    uart_tx_fifo #(
        .fifo_depth_log2(4),
        .divider_width  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_divider(cfg_divider),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Record n line samples starting at the first negedge where the line is low.
    task automatic capture_from_start(input int n);
        cap.delete();
        capb.delete();
        cap_to   = 1'b0;
        cap_wait = 0;
        forever begin
            @(negedge clk);
            cap_wait++;
            if (ser_tx === 1'b0) break;
            if (cap_wait >= 4000) begin
                cap_to = 1'b1;
                break;
            end
        end
        if (!cap_to) begin
            cap.push_back(ser_tx);
            capb.push_back(busy);
            for (int i = 1; i < n; i++) begin
                @(negedge clk);
                cap.push_back(ser_tx);
                capb.push_back(busy);
            end
        end
    endtask

    task automatic capture_now(input int n);
        cap.delete();
        capb.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap.push_back(ser_tx);
            capb.push_back(busy);
        end
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        for (int i = 0; i < div; i++) exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < div; i++) exp_q.push_back(b[k]);
        for (int i = 0; i < div; i++) exp_q.push_back(1'b1);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    // Model receiver: mid-bit sampling of the captured line.
    task automatic decode(input int div);
        int idx;
        logic [7:0] b;
        rxq.delete();
        idx = 0;
        while (idx < cap.size()) begin
            if (cap[idx] === 1'b0) begin
                if (idx + 9 * div + div / 2 >= cap.size()) break;
                for (int k = 0; k < 8; k++)
                    b[k] = cap[idx + div / 2 + (k + 1) * div];
                if (cap[idx + div / 2] === 1'b0 &&
                    cap[idx + 9 * div + div / 2] === 1'b1)
                    rxq.push_back(b);
                idx = idx + 9 * div + div / 2 + 1;
            end else begin
                idx++;
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        valid       = 1'b0;
        data        = 8'h00;
        cfg_divider = 16'd217;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ser_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b want 1", ser_tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", ready);
        end
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d want 0", fifo_level);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int bad;
        do_reset();
        cfg_divider = 16'd217;
        push(8'h55);
        checks++;
        if (ser_tx !== 1'b1 || fifo_level !== 5'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL push_edge: got tx=%b lvl=%0d busy=%b want 1/1/1",
                     ser_tx, fifo_level, busy);
        end
        capture_from_start(2171);
        checks++;
        if (cap_to || cap_wait != 1) begin
            errors++;
            $display("FAIL start_latency: got %0d want 1 (timeout=%0b)",
                     cap_wait, cap_to);
        end
        exp_q.delete();
        add_frame(8'h55, 217);
        add_idle(1);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_55: got %0d bad samples want 0", bad);
        end
        checks++;
        if (capb[2169] !== 1'b1 || capb[2170] !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: got %b%b want 10", capb[2169], capb[2170]);
        end
        checks++;
        if (fifo_level !== 5'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after: got lvl=%0d rdy=%b want 0/1",
                     fifo_level, ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        logic [7:0] msg [3];
        msg = '{8'h41, 8'h0D, 8'h0A};
        do_reset();
        cfg_divider = 16'd217;
        fork
            begin
                for (int i = 0; i < 3; i++) push(msg[i]);
            end
            capture_from_start(6511);
        join
        checks++;
        if (cap_to || cap_wait != 2) begin
            errors++;
            $display("FAIL b2b_latency: got %0d want 2", cap_wait);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) add_frame(msg[i], 217);
        add_idle(1);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_stream: got %0d bad samples want 0", bad);
        end
        checks++;
        if (capb[6509] !== 1'b1 || capb[6510] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %b%b want 10", capb[6509], capb[6510]);
        end
        decode(217);
        checks++;
        if (rxq.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", rxq.size());
        end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== msg[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h want %h", i, rxq[i], msg[i]);
            end
        end
    endtask

    task automatic test_fifo_full();
        int bad;
        logic [4:0] lvl [18];
        logic       rdy [18];
        do_reset();
        cfg_divider = 16'd4;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    valid = 1'b1;
                    data  = 8'(8'h10 + i);
                    @(negedge clk);
                    lvl[i] = fifo_level;
                    rdy[i] = ready;
                end
                valid = 1'b0;
            end
            capture_from_start(17 * 40 + 4);
        join
        checks++;
        if (lvl[1] !== 5'd1) begin
            errors++;
            $display("FAIL full_pop_push: got %0d want 1", lvl[1]);
        end
        checks++;
        if (lvl[15] !== 5'd15 || rdy[15] !== 1'b1) begin
            errors++;
            $display("FAIL full_16th: got %0d/%b want 15/1", lvl[15], rdy[15]);
        end
        checks++;
        if (lvl[16] !== 5'd16 || rdy[16] !== 1'b0) begin
            errors++;
            $display("FAIL full_17th: got %0d/%b want 16/0", lvl[16], rdy[16]);
        end
        checks++;
        if (lvl[17] !== 5'd16 || rdy[17] !== 1'b0) begin
            errors++;
            $display("FAIL full_ignored: got %0d/%b want 16/0", lvl[17], rdy[17]);
        end
        exp_q.delete();
        for (int i = 0; i < 17; i++) add_frame(8'(8'h10 + i), 4);
        add_idle(4);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_stream: got %0d bad samples want 0", bad);
        end
        decode(4);
        checks++;
        if (rxq.size() != 17) begin
            errors++;
            $display("FAIL full_count: got %0d want 17", rxq.size());
        end
    endtask

    task automatic test_push_pop_wrap();
        int bad;
        do_reset();
        cfg_divider = 16'd4;
        fork
            capture_now(2400);
            begin
                for (int i = 0; i < 4; i++) begin
                    valid = 1'b1;
                    data  = 8'(i * 7 + 3);
                    @(negedge clk);
                end
                valid = 1'b0;
                checks++;
                if (fifo_level !== 5'd3) begin
                    errors++;
                    $display("FAIL pp_level3: got %0d want 3", fifo_level);
                end
                repeat (37) @(negedge clk);
                checks++;
                if (fifo_level !== 5'd3 || ser_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL pp_pre: got %0d/%b want 3/1",
                             fifo_level, ser_tx);
                end
                push(8'(4 * 7 + 3));
                checks++;
                if (fifo_level !== 5'd3 || ser_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL pp_same_edge: got %0d/%b want 3/0",
                             fifo_level, ser_tx);
                end
                for (int b = 0; b < 7; b++) begin
                    repeat (200) @(negedge clk);
                    for (int j = 0; j < 5; j++) begin
                        valid = 1'b1;
                        data  = 8'((5 + b * 5 + j) * 7 + 3);
                        @(negedge clk);
                    end
                    valid = 1'b0;
                end
            end
        join
        decode(4);
        checks++;
        if (rxq.size() != 40) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 40", rxq.size());
        end
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (i >= rxq.size() || rxq[i] !== 8'(i * 7 + 3)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_order: got %0d bad bytes want 0", bad);
        end
        checks++;
        if (busy !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL wrap_drain: got %b/%0d want 0/0", busy, fifo_level);
        end
    endtask

    task automatic test_reset_mid_frame();
        int zeros;
        do_reset();
        cfg_divider = 16'd8;
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1;
            data  = (i == 0) ? 8'hA5 : 8'(8'h60 + i);
            @(negedge clk);
        end
        valid = 1'b0;
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++;
            $display("FAIL rst_queued: got %0d want 5", fifo_level);
        end
        repeat (38) @(negedge clk);
        checks++;
        if (ser_tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_bit4: got %b/%b want 0/1", ser_tx, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (ser_tx !== 1'b1 || busy !== 1'b0 ||
            fifo_level !== 5'd0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got tx=%b busy=%b lvl=%0d rdy=%b want 1/0/0/1",
                     ser_tx, busy, fifo_level, ready);
        end
        capture_now(300);
        zeros = 0;
        foreach (cap[i]) if (cap[i] !== 1'b1 || capb[i] !== 1'b0) zeros++;
        checks++;
        if (zeros != 0) begin
            errors++;
            $display("FAIL rst_no_resume: got %0d active samples want 0", zeros);
        end
    endtask

    task automatic test_divider();
        int bad;
        do_reset();
        cfg_divider = 16'd217;
        fork
            capture_from_start(2170 + 1080 + 2);
            begin
                push(8'hC3);
                push(8'h3C);
                repeat (1000) @(negedge clk);
                cfg_divider = 16'd108;
            end
        join
        exp_q.delete();
        add_frame(8'hC3, 217);
        add_frame(8'h3C, 108);
        add_idle(2);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) bad++;
        checks++;
        if (cap_to || bad != 0) begin
            errors++;
            $display("FAIL div_change: got %0d bad samples want 0", bad);
        end
        cfg_divider = 16'd0;
        fork
            push(8'h96);
            capture_from_start(22);
        join
        checks++;
        if (cap_to || cap_wait != 2) begin
            errors++;
            $display("FAIL div0_latency: got %0d want 2", cap_wait);
        end
        exp_q.delete();
        add_frame(8'h96, 2);
        add_idle(2);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= cap.size() || cap[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div0_stream: got %0d bad samples want 0", bad);
        end
    endtask

    initial begin
        reset       = 1'b1;
        valid       = 1'b0;
        data        = 8'h00;
        cfg_divider = 16'd217;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_push_pop_wrap();
        test_reset_mid_frame();
        test_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
